pc_fetch_unit: RTL

Program-counter stage of the single-cycle MIPS subset datapath. It holds the architectural PC, produces PC+4 through a `soma32` instance, and selects the next PC from the sequential, branch, jump and jump-register paths. It buffers a redirect that arrives while fetch is stalled, and it flags misaligned register targets. It feeds the instruction memory address and the branch/link logic downstream.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/soma32.sv | 10 +
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-subset datapath.
// Holds the next-PC source encoding and the pending-redirect state encoding.
package mips_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP,
    PC_JR,
    PC_PEND
  } pc_src_t;

  typedef enum logic {
    PEND_IDLE,
    PEND_FULL
  } pend_state_t;

endpackage

// File: rtl/soma32.sv
// 32-bit modular adder; purely combinational, zero latency, no flow control.
module soma32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC stage: next-PC select (jr > jump > branch > pending > pc+4), one-entry redirect buffer while stalled.
// One-edge latency from inputs to pc; stall holds pc/count and parks any live redirect for the release edge.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  pend_state_t state, state_nxt;
  logic [31:0] pend_target;
  logic [31:0] branch_tgt;
  logic [31:0] live_tgt;
  logic [31:0] next_pc;
  logic        live_vld;
  pc_src_t     sel_src;

  soma32 u_inc (
    .a (pc),
    .b (32'(WORD_BYTES)),
    .y (pc_plus4)
  );

  soma32 u_btgt (
    .a (pc_plus4),
    .b (branch_imm << 2),
    .y (branch_tgt)
  );

  assign live_vld = jr | jump | branch;

  always_comb begin
    live_tgt = pc_plus4;
    sel_src  = PC_SEQ;
    if (jr) begin
      live_tgt = {jr_target[31:2], 2'b00};
      sel_src  = PC_JR;
    end else if (jump) begin
      live_tgt = {pc_plus4[31:28], jump_index, 2'b00};
      sel_src  = PC_JUMP;
    end else if (branch) begin
      live_tgt = branch_tgt;
      sel_src  = PC_BRANCH;
    end else if (state == PEND_FULL) begin
      sel_src  = PC_PEND;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel_src)
      PC_PEND:                     next_pc = pend_target;
      PC_BRANCH, PC_JUMP, PC_JR:   next_pc = live_tgt;
      default:                     next_pc = pc_plus4;
    endcase
  end

  // A live request during stall (re)fills the buffer; any unstalled edge drains it.
  always_comb begin
    state_nxt = state;
    if (stall) begin
      if (live_vld) state_nxt = PEND_FULL;
    end else begin
      state_nxt = PEND_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PEND_IDLE;
      pend_target <= '0;
      pc          <= RESET_PC;
      redirect    <= 1'b0;
      addr_err    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (stall) begin
        redirect <= 1'b0;
        if (live_vld) pend_target <= live_tgt;
      end else begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
        redirect    <= (sel_src != PC_SEQ);
      end
      // JR is accepted whether applied now or parked, so either path flags it.
      if (jr && (jr_target[1:0] != 2'b00)) addr_err <= 1'b1;
    end
  end

endmodule
